// File: rtl/dm_arb_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states, port ownership, latched access fields.
package dm_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    // Latency counter runs MEM_LAT-1 down to 0.
    function automatic int cnt_width(input int mem_lat);
        return (mem_lat < 1) ? 1 : $clog2(mem_lat + 1);
    endfunction

endpackage

// File: rtl/dm_arb_age.sv
// CPU/DMA priority decision with DMA starvation ageing; grants are combinational and only valid while idle.
// dma_wait counts consecutive lost IDLE arbitrations and saturates at DMA_MAX_WAIT.
module dm_arb_age #(
    parameter int DMA_MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic cpu_req,
    input  logic dma_req,
    input  logic idle,
    output logic grant_cpu,
    output logic grant_dma
);

    localparam int             WW   = $clog2(DMA_MAX_WAIT + 1);
    localparam logic [WW-1:0]  WMAX = WW'(DMA_MAX_WAIT);

    logic [WW-1:0] dma_wait;
    logic          dma_aged;

    always_comb begin
        dma_aged  = (dma_wait >= WMAX);
        grant_cpu = 1'b0;
        grant_dma = 1'b0;
        if (idle) begin
            if (cpu_req && dma_req) begin
                grant_dma = dma_aged;
                grant_cpu = ~dma_aged;
            end else begin
                grant_cpu = cpu_req;
                grant_dma = dma_req;
            end
        end
    end

    // A DMA loss can only happen in IDLE with dma_req high and no grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            dma_wait <= '0;
        end else if (!dma_req || grant_dma) begin
            dma_wait <= '0;
        end else if (idle && !dma_aged) begin
            dma_wait <= dma_wait + 1'b1;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single-port data memory between CPU and DMA; each access is one IDLE cycle plus MEM_LAT ACCESS cycles.
// CPU is held by combinational cpu_stall until its done cycle; DMA holds dma_req until the one-cycle dma_done pulse.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int MEM_LAT      = 1,
    parameter int DMA_MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_done,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata
);

    localparam int            CW       = cnt_width(MEM_LAT);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

    state_t        state, state_nxt;
    owner_t        owner, owner_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    acc_t          acc, acc_nxt;
    logic [31:0]   cpu_hold, dma_hold;
    logic          idle, done, cpu_done;
    logic          grant_cpu, grant_dma;

    assign idle = (state == IDLE);

    dm_arb_age #(
        .DMA_MAX_WAIT (DMA_MAX_WAIT)
    ) u_age (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .dma_req   (dma_req),
        .idle      (idle),
        .grant_cpu (grant_cpu),
        .grant_dma (grant_dma)
    );

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        done      = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (grant_dma) begin
                    state_nxt     = ACCESS;
                    owner_nxt     = OWN_DMA;
                    cnt_nxt       = CNT_LOAD;
                    acc_nxt.we    = dma_we;
                    acc_nxt.addr  = dma_addr;
                    acc_nxt.wdata = dma_wdata;
                end else if (grant_cpu) begin
                    state_nxt     = ACCESS;
                    owner_nxt     = OWN_CPU;
                    cnt_nxt       = CNT_LOAD;
                    acc_nxt.we    = cpu_we;
                    acc_nxt.addr  = cpu_addr;
                    acc_nxt.wdata = cpu_wdata;
                end
            end
            ACCESS: begin
                mem_we    = acc.we;
                mem_re    = ~acc.we;
                mem_addr  = acc.addr;
                mem_wdata = acc.wdata;
                if (cnt == '0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                    owner_nxt = OWN_NONE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= OWN_NONE;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            cnt   <= cnt_nxt;
            acc   <= acc_nxt;
        end
    end

    assign cpu_done  = done && (owner == OWN_CPU);
    assign dma_done  = done && (owner == OWN_DMA);
    assign cpu_stall = cpu_req & ~cpu_done;

    // Done-cycle data bypasses the hold registers so the pipeline sees it before the edge.
    assign cpu_rdata = cpu_done ? mem_rdata : cpu_hold;
    assign dma_rdata = dma_done ? mem_rdata : dma_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_hold <= '0;
            dma_hold <= '0;
        end else begin
            if (cpu_done) cpu_hold <= mem_rdata;
            if (dma_done) dma_hold <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: three instances (MEM_LAT 1, 2, 3) each backed by a small word memory.
module tb_dm_arbiter;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset     [N];
    logic        cpu_req   [N];
    logic        cpu_we    [N];
    logic [31:0] cpu_addr  [N];
    logic [31:0] cpu_wdata [N];
    logic [31:0] cpu_rdata [N];
    logic        cpu_stall [N];
    logic        dma_req   [N];
    logic        dma_we    [N];
    logic [31:0] dma_addr  [N];
    logic [31:0] dma_wdata [N];
    logic [31:0] dma_rdata [N];
    logic        dma_done  [N];
    logic [31:0] mem_addr  [N];
    logic [31:0] mem_wdata [N];
    logic        mem_we    [N];
    logic        mem_re    [N];
    logic [31:0] mem_rdata [N];

    logic [31:0] mem_arr [N][256];
    bit          mem_vld [N][256];
    logic [31:0] ref_mem [logic [31:0]];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        case (a)
            32'h10:  return 32'hDEADBEEF;
            32'h40:  return 32'hA5A5A5A5;
            default: return 32'hC0DE0000 | a;
        endcase
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        dm_arbiter #(
            .MEM_LAT      (g + 1),
            .DMA_MAX_WAIT (4)
        ) u_dut (
            .clk       (clk),
            .reset     (reset[g]),
            .cpu_req   (cpu_req[g]),
            .cpu_we    (cpu_we[g]),
            .cpu_addr  (cpu_addr[g]),
            .cpu_wdata (cpu_wdata[g]),
            .cpu_rdata (cpu_rdata[g]),
            .cpu_stall (cpu_stall[g]),
            .dma_req   (dma_req[g]),
            .dma_we    (dma_we[g]),
            .dma_addr  (dma_addr[g]),
            .dma_wdata (dma_wdata[g]),
            .dma_rdata (dma_rdata[g]),
            .dma_done  (dma_done[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_we    (mem_we[g]),
            .mem_re    (mem_re[g]),
            .mem_rdata (mem_rdata[g])
        );
        assign mem_rdata[g] = !mem_re[g] ? 32'h0 :
                              mem_vld[g][mem_addr[g][9:2]] ? mem_arr[g][mem_addr[g][9:2]] :
                              init_word(mem_addr[g]);
    end

    always @(posedge clk) begin
        for (int g = 0; g < N; g++) begin
            if (mem_we[g]) begin
                mem_arr[g][mem_addr[g][9:2]] <= mem_wdata[g];
                mem_vld[g][mem_addr[g][9:2]] <= 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr(input int g);
        cpu_req[g] = 0; cpu_we[g] = 0; cpu_addr[g] = 0; cpu_wdata[g] = 0;
        dma_req[g] = 0; dma_we[g] = 0; dma_addr[g] = 0; dma_wdata[g] = 0;
    endtask

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // One request from one port, held until its completion is seen.
    task automatic run_txn(input int g, input bit dma, input bit we, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] rd, output int cyc);
        cyc = 0;
        rd  = 'x;
        if (dma) begin
            dma_req[g] = 1; dma_we[g] = we; dma_addr[g] = a; dma_wdata[g] = wd;
        end else begin
            cpu_req[g] = 1; cpu_we[g] = we; cpu_addr[g] = a; cpu_wdata[g] = wd;
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            cyc++;
            if (dma ? dma_done[g] : !cpu_stall[g]) begin
                rd = dma ? dma_rdata[g] : cpu_rdata[g];
                break;
            end
            tick();
        end
        tick();
        clr(g);
    endtask

    // Cycle-level reference: an access occupies MEM_LAT cycles after the IDLE grant cycle.
    task automatic rand_run(input int g, input int ncyc);
        int          lat, left, own, wt, win;
        bit          m_we, done, c_done, d_done;
        logic [31:0] m_a, m_d;
        lat = g + 1; left = 0; own = 0; wt = 0; m_we = 0; m_a = 0; m_d = 0;
        ref_mem.delete();
        clr(g);
        reset[g] = 1;
        tick(); tick();
        reset[g] = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            done   = (left == 1);
            c_done = done && own == 1;
            d_done = done && own == 2;
            chk("rnd_mem_we", mem_we[g], left > 0 && m_we);
            chk("rnd_mem_re", mem_re[g], left > 0 && !m_we);
            if (left > 0) chk("rnd_mem_addr", mem_addr[g], m_a);
            if (left > 0 && m_we) chk("rnd_mem_wdata", mem_wdata[g], m_d);
            chk("rnd_cpu_stall", cpu_stall[g], cpu_req[g] && !c_done);
            chk("rnd_dma_done", dma_done[g], d_done);
            if (c_done && !m_we) chk("rnd_cpu_rdata", cpu_rdata[g], ref_rd(m_a));
            if (d_done && !m_we) chk("rnd_dma_rdata", dma_rdata[g], ref_rd(m_a));
            if (left == 0) begin
                win = 0;
                if (cpu_req[g] && dma_req[g]) win = (wt >= 4) ? 2 : 1;
                else if (cpu_req[g])          win = 1;
                else if (dma_req[g])          win = 2;
                wt = (!dma_req[g] || win == 2) ? 0 : ((wt < 4) ? wt + 1 : 4);
                if (win != 0) begin
                    own  = win;
                    left = lat;
                    m_we = (win == 2) ? dma_we[g]    : cpu_we[g];
                    m_a  = (win == 2) ? dma_addr[g]  : cpu_addr[g];
                    m_d  = (win == 2) ? dma_wdata[g] : cpu_wdata[g];
                end
            end else begin
                if (!dma_req[g]) wt = 0;
                if (done && m_we) ref_mem[m_a] = m_d;
                left--;
            end
            tick();
            if (c_done || !cpu_req[g]) begin
                cpu_req[g]   = ($urandom_range(0, 1) == 1);
                cpu_we[g]    = $urandom_range(0, 1);
                cpu_addr[g]  = 32'h100 + ($urandom_range(0, 15) << 2);
                cpu_wdata[g] = $urandom;
            end
            if (d_done || !dma_req[g]) begin
                dma_req[g]   = ($urandom_range(0, 2) == 0);
                dma_we[g]    = $urandom_range(0, 1);
                dma_addr[g]  = 32'h100 + ($urandom_range(0, 15) << 2);
                dma_wdata[g] = $urandom;
            end
        end
        clr(g);
        reset[g] = 1;
        tick();
        reset[g] = 0;
    endtask

    typedef struct {
        int          g;
        bit          dma;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          exp_cyc;
    } vec_t;

    initial begin
        vec_t        vt [7];
        logic [31:0] rd;
        int          cyc, ng, nd, n_acc, wide;
        bit          prev, stall_seen, just;
        logic [9:0]  order;
        int          dc [2];
        logic [31:0] dr [2];

        vt[0] = '{0, 0, 0, 32'h10, 32'h0,        32'hDEADBEEF, 2};
        vt[1] = '{2, 0, 1, 32'h24, 32'hCAFEF00D, 32'h0,        4};
        vt[2] = '{2, 0, 0, 32'h24, 32'h0,        32'hCAFEF00D, 4};
        vt[3] = '{0, 1, 0, 32'h40, 32'h0,        32'hA5A5A5A5, 2};
        vt[4] = '{1, 1, 1, 32'h44, 32'h0BADF00D, 32'h0,        3};
        vt[5] = '{1, 0, 0, 32'h44, 32'h0,        32'h0BADF00D, 3};
        vt[6] = '{1, 1, 0, 32'h48, 32'h0,        32'hC0DE0048, 3};

        for (int g = 0; g < N; g++) begin
            clr(g);
            reset[g] = 1;
        end
        tick(); tick();
        for (int g = 0; g < N; g++) reset[g] = 0;

        @(negedge clk);
        for (int g = 0; g < N; g++) begin
            chk($sformatf("rst%0d_mem_we", g),    mem_we[g],    0);
            chk($sformatf("rst%0d_mem_re", g),    mem_re[g],    0);
            chk($sformatf("rst%0d_mem_addr", g),  mem_addr[g],  0);
            chk($sformatf("rst%0d_mem_wdata", g), mem_wdata[g], 0);
            chk($sformatf("rst%0d_dma_done", g),  dma_done[g],  0);
            chk($sformatf("rst%0d_cpu_rdata", g), cpu_rdata[g], 0);
            chk($sformatf("rst%0d_dma_rdata", g), dma_rdata[g], 0);
            chk($sformatf("rst%0d_cpu_stall", g), cpu_stall[g], 0);
        end
        tick();

        for (int i = 0; i < 7; i++) begin
            run_txn(vt[i].g, vt[i].dma, vt[i].we, vt[i].addr, vt[i].wdata, rd, cyc);
            chk($sformatf("vec%0d_cycles", i), cyc, vt[i].exp_cyc);
            if (!vt[i].we) chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
        end

        // CPU read, MEM_LAT=1
        cpu_req[0] = 1; cpu_we[0] = 0; cpu_addr[0] = 32'h10;
        @(negedge clk);
        chk("rd1_c0_stall", cpu_stall[0], 1);
        chk("rd1_c0_mem_re", mem_re[0], 0);
        tick();
        @(negedge clk);
        chk("rd1_c1_mem_re", mem_re[0], 1);
        chk("rd1_c1_mem_addr", mem_addr[0], 32'h10);
        chk("rd1_c1_stall", cpu_stall[0], 0);
        chk("rd1_c1_rdata", cpu_rdata[0], 32'hDEADBEEF);
        tick();
        clr(0);
        @(negedge clk);
        chk("rd1_hold_rdata", cpu_rdata[0], 32'hDEADBEEF);
        chk("rd1_c2_mem_re", mem_re[0], 0);
        tick();

        // CPU write, MEM_LAT=3
        cpu_req[2] = 1; cpu_we[2] = 1; cpu_addr[2] = 32'h20; cpu_wdata[2] = 32'h12345678;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("wr3_c%0d_mem_we", c), mem_we[2], c >= 1);
            chk($sformatf("wr3_c%0d_stall", c), cpu_stall[2], c <= 2);
            if (c >= 1) begin
                chk($sformatf("wr3_c%0d_addr", c), mem_addr[2], 32'h20);
                chk($sformatf("wr3_c%0d_wdata", c), mem_wdata[2], 32'h12345678);
            end
            if (c < 3) tick();
        end
        tick();
        clr(2);
        run_txn(2, 0, 0, 32'h20, 0, rd, cyc);
        chk("wr3_readback", rd, 32'h12345678);

        // Contention, both held continuously: four CPU grants then one DMA, repeating
        cpu_req[0] = 1; cpu_addr[0] = 32'h10;
        dma_req[0] = 1; dma_addr[0] = 32'h40;
        ng = 0; order = '0; prev = 0; wide = 0;
        for (int c = 0; c < 40 && ng < 10; c++) begin
            @(negedge clk);
            if (dma_done[0] && prev) wide++;
            prev = dma_done[0];
            if (cpu_req[0] && !cpu_stall[0]) begin order[ng] = 1'b0; ng++; end
            if (dma_done[0]) begin order[ng] = 1'b1; ng++; end
            if (ng < 10) tick();
        end
        tick();
        clr(0);
        chk("cont_grants", ng, 10);
        chk("cont_order", order, 10'h210);
        @(negedge clk);
        if (dma_done[0] && prev) wide++;
        chk("cont_dma_done_width", wide, 0);
        tick();

        // DMA alone, MEM_LAT=1
        dma_req[0] = 1; dma_we[0] = 0; dma_addr[0] = 32'h40;
        stall_seen = 0;
        @(negedge clk);
        stall_seen |= cpu_stall[0];
        chk("dma1_c0_done", dma_done[0], 0);
        tick();
        @(negedge clk);
        stall_seen |= cpu_stall[0];
        chk("dma1_c1_mem_re", mem_re[0], 1);
        chk("dma1_c1_mem_addr", mem_addr[0], 32'h40);
        chk("dma1_c1_done", dma_done[0], 1);
        chk("dma1_c1_rdata", dma_rdata[0], 32'hA5A5A5A5);
        tick();
        clr(0);
        @(negedge clk);
        stall_seen |= cpu_stall[0];
        chk("dma1_c2_done", dma_done[0], 0);
        chk("dma1_c2_hold", dma_rdata[0], 32'hA5A5A5A5);
        chk("dma1_no_stall", stall_seen, 0);
        tick();

        // Reset during the second ACCESS cycle of a MEM_LAT=3 write
        cpu_req[2] = 1; cpu_we[2] = 1; cpu_addr[2] = 32'h30; cpu_wdata[2] = 32'h77;
        tick(); tick();
        reset[2] = 1;
        @(negedge clk);
        chk("rst_mid_c2_mem_we", mem_we[2], 1);
        chk("rst_mid_c2_stall", cpu_stall[2], 1);
        tick();
        @(negedge clk);
        chk("rst_mid_c3_mem_we", mem_we[2], 0);
        chk("rst_mid_c3_mem_re", mem_re[2], 0);
        chk("rst_mid_c3_dma_done", dma_done[2], 0);
        chk("rst_mid_c3_stall", cpu_stall[2], cpu_req[2]);
        tick();
        reset[2] = 0;
        clr(2);
        @(negedge clk);
        chk("rst_mid_c4_mem_we", mem_we[2], 0);
        chk("rst_mid_c4_stall", cpu_stall[2], 0);
        tick();

        // Back-to-back CPU loads, MEM_LAT=2
        cpu_req[1] = 1; cpu_we[1] = 0; cpu_addr[1] = 32'h50;
        nd = 0; n_acc = 0; prev = 0; dc[0] = -1; dc[1] = -1; dr[0] = 0; dr[1] = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            just = 0;
            if (mem_re[1] && !prev) n_acc++;
            prev = mem_re[1];
            if (cpu_req[1] && !cpu_stall[1]) begin
                if (nd < 2) begin dc[nd] = c; dr[nd] = cpu_rdata[1]; end
                nd++;
                just = 1;
            end
            tick();
            if (just && nd == 1) cpu_addr[1] = 32'h54;
            if (just && nd >= 2) cpu_req[1] = 0;
        end
        clr(1);
        chk("b2b_ndone", nd, 2);
        chk("b2b_done0_cycle", dc[0], 2);
        chk("b2b_done1_cycle", dc[1], 5);
        chk("b2b_rdata0", dr[0], 32'hC0DE0050);
        chk("b2b_rdata1", dr[1], 32'hC0DE0054);
        chk("b2b_mem_accesses", n_acc, 2);

        for (int g = 0; g < N; g++) rand_run(g, 400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
